strela_clock_gate_ctrl: RTL
===========================

// Module: strela_clock_gate_ctrl
// PURPOSE
//  Controller that drives the enable input of the STRELA clock gate cell.
//  Watches accelerator activity and, after a programmable idle window, drops
//  clk_en_o to stop the fabric clock. Re-enables the clock on a wake event or a
//  bus access, then holds ready_o low for a fixed settle window before access.
//  Lives in the always-on clock domain, beside the gate cell.
// PARAMETERS
//  IDLE_W      8  width of idle_thr_i and of the internal idle counter
//  WAKE_CYCLES 2  cycles from clock re-enable to ready_o=1 (legal 1..15)
//  CNT_W       16 width of gate_cnt_o (gating-episode counter)
// PORTS
//  clk_i       in  1       always-on clock
//  rst_i       in  1       asynchronous reset, active-high
//  auto_en_i   in  1       1 = automatic gating allowed
//  idle_thr_i  in  IDLE_W  idle cycles required before gating; 0 treated as 1
//  busy_i      in  1       accelerator activity (sampled only in RUN/COUNT)
//  wake_i      in  1       external wake event (e.g. start pulse)
//  req_i       in  1       config/bus access request
//  ready_o     out 1       access may complete; req_i held until ready_o=1
//  clk_en_o    out 1       enable to clock gate cell (en_i)
//  gated_o     out 1       1 while in GATED
//  clr_cnt_i   in  1       synchronous clear of gate_cnt_o
//  gate_cnt_o  out CNT_W   number of entries into GATED, saturating
// BEHAVIOUR
//  Reset (async, rst_i=1): state=RUN, clk_en_o=1, ready_o=1, gated_o=0,
//   idle counter=0, wake counter=0, gate_cnt_o=0.
//  Moore outputs from the registered state: RUN/COUNT: clk_en_o=1, ready_o=1.
//   GATED: clk_en_o=0, ready_o=0, gated_o=1. WAKE: clk_en_o=1, ready_o=0.
//  Define act = busy_i | req_i | wake_i.
//  RUN: auto_en_i & !act -> COUNT, idle counter loads 1; else stay.
//  COUNT: act | !auto_en_i -> RUN, counter clears.
//   Else if counter >= max(idle_thr_i,1) -> GATED, gate_cnt_o += 1.
//   Else counter += 1, saturating at all-ones.
//   Net effect: thr=N (N>=1) with continuous idle from the first idle cycle
//   T gives clk_en_o=0 from cycle T+N+1.
//   idle_thr_i changes mid-COUNT take effect on the next compare.
//  GATED: req_i | wake_i | !auto_en_i -> WAKE, wake counter loads WAKE_CYCLES-1.
//   busy_i is ignored; it comes from the stopped domain.
//  WAKE: wake counter==0 -> RUN, so ready_o=1 exactly WAKE_CYCLES cycles after
//   clk_en_o rises. Else decrement. req_i/wake_i/busy_i in WAKE are ignored
//   and do not restart the counter.
//  Handshake: a transfer completes on the cycle req_i & ready_o. A req_i
//   arriving in COUNT aborts gating the same cycle and causes no stall.
//  gate_cnt_o: increments on each COUNT->GATED transition and saturates at
//   2^CNT_W-1. If clr_cnt_i coincides with an increment, the counter becomes 0.
//  auto_en_i deassert while GATED wakes the fabric; it never stays gated
//   with auto_en_i=0.
//  clk_en_o is a flop output, glitch-free, and never changes within a cycle.
// TESTING
//  1 Reset, auto_en=1, thr=4, busy=0 from cycle 0 -> clk_en_o=0 from cycle 5,
//    gated_o=1, gate_cnt_o=1.
//  2 Gated, req_i=1 at cycle T -> clk_en_o=1 at T+1, ready_o=1 at T+3
//    (WAKE_CYCLES=2), req held; transfer at T+3.
//  3 thr=4, busy pulse on the 3rd idle cycle -> back to RUN, clk_en_o stays 1;
//    gating occurs 4 idle cycles after busy falls.
//  4 thr=0 -> gating after 1 idle cycle; thr=255 -> after 255 cycles.
//  5 CNT_W=2, gate/wake 5 times -> gate_cnt_o saturates at 3;
//    clr_cnt_i with a gating entry -> 0.
//  6 Assert rst_i mid-WAKE and mid-GATED -> all outputs at reset values
//    immediately (async), state RUN after release.

Source files
------------

// File: rtl/strela_clock_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : strela_clock_gate_ctrl
// Brief   : Drives the enable of the STRELA fabric clock gate. It stops the
//           clock after a programmable idle window and restarts it on a wake
//           event or a bus access, then holds off ready for a settle window.
//           Sits in the always-on domain next to the gate cell.
// Revision: 1.0 - initial release
// ============================================================================
module strela_clock_gate_ctrl #(
  parameter int IDLE_W      = 8,
  parameter int WAKE_CYCLES = 2,
  parameter int CNT_W       = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              auto_en_i,
  input  logic [IDLE_W-1:0] idle_thr_i,
  input  logic              busy_i,
  input  logic              wake_i,
  input  logic              req_i,
  output logic              ready_o,
  output logic              clk_en_o,
  output logic              gated_o,
  input  logic              clr_cnt_i,
  output logic [CNT_W-1:0]  gate_cnt_o
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_COUNT = 2'd1,
    ST_GATED = 2'd2,
    ST_WAKE  = 2'd3
  } state_t;

  // Settle counter reload; WAKE counts this down to zero, inclusive.
  localparam logic [3:0] C_WAKE_LOAD = 4'(WAKE_CYCLES - 1);

  state_t              r_state;
  state_t              w_state_nx;
  logic [IDLE_W-1:0]   r_idle_cnt;
  logic [IDLE_W-1:0]   w_idle_nx;
  logic [3:0]          r_wake_cnt;
  logic [3:0]          w_wake_nx;
  logic [CNT_W-1:0]    r_gate_cnt;
  logic                w_gate_inc;
  logic                w_act;
  logic [IDLE_W-1:0]   w_thr_eff;
  logic                r_clk_en;
  logic                r_ready;
  logic                r_gated;

  assign w_act     = busy_i | req_i | wake_i;
  // A zero threshold would gate with no idle time at all; treat it as one.
  assign w_thr_eff = (idle_thr_i == '0) ? IDLE_W'(1) : idle_thr_i;

  // Next-state, counter updates and gating-episode strobe.
  always_comb begin
    w_state_nx = r_state;
    w_idle_nx  = r_idle_cnt;
    w_wake_nx  = r_wake_cnt;
    w_gate_inc = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (auto_en_i && !w_act) begin
          w_state_nx = ST_COUNT;
          w_idle_nx  = IDLE_W'(1);
        end else begin
          w_idle_nx  = '0;
        end
      end
      ST_COUNT: begin
        if (w_act || !auto_en_i) begin
          w_state_nx = ST_RUN;
          w_idle_nx  = '0;
        end else if (r_idle_cnt >= w_thr_eff) begin
          w_state_nx = ST_GATED;
          w_idle_nx  = '0;
          w_gate_inc = 1'b1;
        end else if (r_idle_cnt != '1) begin
          w_idle_nx  = r_idle_cnt + IDLE_W'(1);
        end
      end
      ST_GATED: begin
        // busy_i originates in the stopped domain and is not trusted here.
        if (req_i || wake_i || !auto_en_i) begin
          w_state_nx = ST_WAKE;
          w_wake_nx  = C_WAKE_LOAD;
        end
      end
      ST_WAKE: begin
        // Settle window runs to completion regardless of further activity.
        if (r_wake_cnt == 4'd0) begin
          w_state_nx = ST_RUN;
        end else begin
          w_wake_nx  = r_wake_cnt - 4'd1;
        end
      end
      default: begin
        w_state_nx = ST_RUN;
        w_idle_nx  = '0;
        w_wake_nx  = '0;
      end
    endcase
  end

  // State and counter registers; outputs are flopped from the next state so
  // the gate enable comes straight from a flop and cannot glitch.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= ST_RUN;
      r_idle_cnt <= '0;
      r_wake_cnt <= '0;
      r_clk_en   <= 1'b1;
      r_ready    <= 1'b1;
      r_gated    <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_idle_cnt <= w_idle_nx;
      r_wake_cnt <= w_wake_nx;
      r_clk_en   <= (w_state_nx != ST_GATED);
      r_ready    <= (w_state_nx == ST_RUN) || (w_state_nx == ST_COUNT);
      r_gated    <= (w_state_nx == ST_GATED);
    end
  end

  // Saturating gating-episode counter; clear wins over a same-cycle increment.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_gate_cnt <= '0;
    end else if (clr_cnt_i) begin
      r_gate_cnt <= '0;
    end else if (w_gate_inc && (r_gate_cnt != '1)) begin
      r_gate_cnt <= r_gate_cnt + CNT_W'(1);
    end
  end

  assign clk_en_o   = r_clk_en;
  assign ready_o    = r_ready;
  assign gated_o    = r_gated;
  assign gate_cnt_o = r_gate_cnt;

endmodule
`default_nettype wire
